mac_operand_sequencer: RTL and testbench
========================================

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning memory read latency in cycles (legal 0 or 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries (must be at least RD_LAT+1).
REQ-003 SHALL have port clock  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port start  in  1  meaning a one-cycle job request.
REQ-006 SHALL have port sec_a  in  4  meaning the sector for operand A, captured at start.
REQ-007 SHALL have port sec_b  in  4  meaning the sector for operand B, captured at start.
REQ-008 SHALL have port base_addr  in  4  meaning the first word address, captured at start.
REQ-009 SHALL have port count  in  5  meaning words per operand (0..16), captured at start.
REQ-010 SHALL have ports read_add_1, read_add_2  out  4  meaning memory read addresses for ports 1 and 2.
REQ-011 SHALL have ports read_sector_selector_1, read_sector_selector_2  out  4  meaning memory sector selects.
REQ-012 SHALL have ports read_data_1, read_data_2  in  16  meaning memory read data.
REQ-013 SHALL have ports op_a, op_b  out  16  meaning the operand pair to the MAC.
REQ-014 SHALL have port op_valid  out  1  meaning the operand pair is valid.
REQ-015 SHALL have port op_ready  in  1  meaning the MAC accepts the pair.
REQ-016 SHALL have port op_last  out  1  meaning the current pair is the final pair of the job.
REQ-017 SHALL have port busy  out  1  meaning a job is in progress.
REQ-018 SHALL have port done  out  1  meaning a one-cycle job-completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, DRAIN and FIN.
REQ-020 IDLE: start=1 SHALL capture sec_a, sec_b, base_addr and count, then go to ISSUE, or to FIN when count=0.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 ISSUE: read_add_1 and read_add_2 SHALL both equal (base_addr+i) mod 16, with i = reads issued so far; read_sector_selector_1=sec_a and read_sector_selector_2=sec_b for the whole job.
REQ-023 A read SHALL be issued only when (FIFO occupancy + reads in flight) < FIFO_DEPTH; otherwise the address SHALL hold.
REQ-024 Read data SHALL be pushed into the FIFO exactly RD_LAT cycles after issue.
REQ-025 With RD_LAT=0, data SHALL be sampled in the same cycle the read is issued.
REQ-026 After the count-th issue, the FSM SHALL go to DRAIN.
REQ-027 DRAIN: the FSM SHALL go to FIN when the final pair (op_last=1) is accepted (op_valid & op_ready).
REQ-028 FIN: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-029 The output SHALL follow valid/ready rules: op_a, op_b and op_last held stable while op_valid=1 and op_ready=0; op_valid never withdrawn before acceptance.
REQ-030 FIFO push and pop in the same cycle SHALL be legal; occupancy SHALL be unchanged; no overflow, no data loss.
REQ-031 Pairs SHALL emerge in address order; op_last SHALL be 1 only on the count-th pair.
REQ-032 Address SHALL wrap 15->0 without error.
REQ-033 busy SHALL be 1 in ISSUE, DRAIN and FIN, and 0 in IDLE.
REQ-034 When count=16, exactly 16 pairs SHALL be delivered and the address SHALL return to base_addr.

Reset
REQ-035 rst_n=0 SHALL immediately force the following: FSM=IDLE; FIFO empty; in-flight count 0; op_valid=0, op_last=0, busy=0, done=0; op_a=op_b=0; read addresses and selectors = 0.
REQ-036 Reset mid-job SHALL abort the job with no done pulse; after release the block SHALL accept a new start.

Verification
REQ-037 Scenario 1: sec_a=2, sec_b=7, base=0, count=4, op_ready=1, RD_LAT=1 -> pairs mem[2][0..3] / mem[7][0..3]; op_last on the 4th pair; done one cycle after the 4th acceptance.
REQ-038 Scenario 2: base=14, count=4 -> addresses 14, 15, 0, 1 in order.
REQ-039 Scenario 3: count=8 with op_ready toggling 1,0,0,1,... -> all 8 pairs in order, each held stable while stalled, no duplicates or drops, and issues stall while the FIFO plus in-flight reads is full.
REQ-040 Scenario 4: count=0 -> busy for one cycle, done pulse, op_valid never 1.
REQ-041 Scenario 5: start pulsed during a count=5 job -> ignored; exactly 5 pairs; one done.
REQ-042 Scenario 6: rst_n low after the 2nd pair of a count=6 job -> all outputs 0 at once, no done; a new count=3 job afterwards completes normally.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Fetches paired A/B operands from two sector memory ports and streams them to a MAC.
// Latency: RD_LAT cycles from read issue to FIFO push, plus one cycle until op_valid.
// Backpressure: op_ready stalls the FIFO head, and reads stop while FIFO plus in-flight reads is full.

module mac_operand_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] occ
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_vld = (occ != '0);
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop_vld & pop_rdy;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_vld, do_pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

module mac_operand_sequencer #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  sec_a,
    input  logic [3:0]  sec_b,
    input  logic [3:0]  base_addr,
    input  logic [4:0]  count,
    output logic [3:0]  read_add_1,
    output logic [3:0]  read_add_2,
    output logic [3:0]  read_sector_selector_1,
    output logic [3:0]  read_sector_selector_2,
    input  logic [15:0] read_data_1,
    input  logic [15:0] read_data_2,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        op_last,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    state_t        state;
    logic [4:0]    count_q;
    logic [4:0]    issued_q;
    logic [4:0]    pushed_q;
    logic [CW-1:0] occ;
    logic [CW:0]   pending;
    logic          in_flight;
    logic          issue;
    logic          push_vld;
    pair_t         push_dat;
    pair_t         head;
    logic          fifo_vld;
    logic          accept;

    // Credit check counts reads still on their way so the FIFO can never overflow.
    assign pending = {1'b0, occ} + (CW + 1)'(in_flight);
    assign issue   = (state == ISSUE) && (pending < (CW + 1)'(FIFO_DEPTH));

    generate
        if (RD_LAT == 0) begin : g_comb_rd
            assign in_flight = 1'b0;
            assign push_vld  = issue;
        end else begin : g_reg_rd
            logic rd_pend_q;
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    rd_pend_q <= 1'b0;
                end else begin
                    rd_pend_q <= issue;
                end
            end
            assign in_flight = rd_pend_q;
            assign push_vld  = rd_pend_q;
        end
    endgenerate

    assign push_dat.last = (pushed_q == count_q - 5'd1);
    assign push_dat.a    = read_data_1;
    assign push_dat.b    = read_data_2;

    mac_operand_fifo #(
        .W     ($bits(pair_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock    (clock),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (op_ready),
        .pop_vld  (fifo_vld),
        .pop_dat  (head),
        .occ      (occ)
    );

    // Data lines read as zero whenever no pair is offered.
    assign op_valid = fifo_vld;
    assign op_a     = fifo_vld ? head.a : 16'd0;
    assign op_b     = fifo_vld ? head.b : 16'd0;
    assign op_last  = fifo_vld & head.last;
    assign accept   = op_valid & op_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            count_q                <= '0;
            issued_q               <= '0;
            pushed_q               <= '0;
            read_add_1             <= '0;
            read_add_2             <= '0;
            read_sector_selector_1 <= '0;
            read_sector_selector_2 <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push_vld) begin
                pushed_q <= pushed_q + 5'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        read_sector_selector_1 <= sec_a;
                        read_sector_selector_2 <= sec_b;
                        read_add_1             <= base_addr;
                        read_add_2             <= base_addr;
                        count_q                <= count;
                        issued_q               <= '0;
                        pushed_q               <= '0;
                        busy                   <= 1'b1;
                        if (count == 5'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        read_add_1 <= read_add_1 + 4'd1;
                        read_add_2 <= read_add_2 + 4'd1;
                        issued_q   <= issued_q + 5'd1;
                        if (issued_q + 5'd1 == count_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && op_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: table of jobs, random jobs and hand-written corner sequences,
// all checked against a pair queue built from the job parameters and a memory array.
module tb_mac_operand_sequencer;
    logic        clock;
    logic        rst_n;
    logic        start;
    logic [3:0]  sec_a, sec_b, base_addr;
    logic [4:0]  count;
    logic [3:0]  read_add_1, read_add_2;
    logic [3:0]  read_sector_selector_1, read_sector_selector_2;
    logic [15:0] read_data_1, read_data_2;
    logic [15:0] op_a, op_b;
    logic        op_valid, op_ready, op_last, busy, done;

    mac_operand_sequencer #(.RD_LAT(1), .FIFO_DEPTH(2)) dut (
        .clock                  (clock),
        .rst_n                  (rst_n),
        .start                  (start),
        .sec_a                  (sec_a),
        .sec_b                  (sec_b),
        .base_addr              (base_addr),
        .count                  (count),
        .read_add_1             (read_add_1),
        .read_add_2             (read_add_2),
        .read_sector_selector_1 (read_sector_selector_1),
        .read_sector_selector_2 (read_sector_selector_2),
        .read_data_1            (read_data_1),
        .read_data_2            (read_data_2),
        .op_a                   (op_a),
        .op_b                   (op_b),
        .op_valid               (op_valid),
        .op_ready               (op_ready),
        .op_last                (op_last),
        .busy                   (busy),
        .done                   (done)
    );

    typedef struct packed {
        logic        last;
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    typedef struct {
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] base;
        logic [4:0] cnt;
        int         mode;       // 0: ready always, 1: ready 1,0,0 repeating, 2: random
        bit         mid_start;
        int         exp_pairs;
        int         exp_dones;
    } vec_t;

    logic [15:0] mem [16][16];
    pair_t       exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          pair_cnt, done_cnt, valid_cyc, busy_cyc;
    logic [3:0]  job_sa, job_sb;
    bit          prev_stall;
    pair_t       prev_p;
    vec_t        vecs [7];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Sector memory with one cycle of read latency.
    always @(posedge clock) begin
        read_data_1 <= mem[read_sector_selector_1][read_add_1];
        read_data_2 <= mem[read_sector_selector_2][read_add_2];
    end

    task automatic cmp_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                cmp_val("hold_valid", 32'(op_valid), 32'd1);
                cmp_val("hold_data", {15'd0, op_last, op_a}, {15'd0, prev_p.last, prev_p.a});
                cmp_val("hold_b", 32'(op_b), 32'(prev_p.b));
            end
            if (busy) begin
                cmp_val("sel_1", 32'(read_sector_selector_1), 32'(job_sa));
                cmp_val("sel_2", 32'(read_sector_selector_2), 32'(job_sb));
                cmp_val("addr_pair", 32'(read_add_2), 32'(read_add_1));
                busy_cyc++;
            end
            if (op_valid) valid_cyc++;
            if (done) begin
                done_cnt++;
                cmp_val("done_busy", 32'(busy), 32'd1);
            end
            if (op_valid && op_ready) begin
                if (exp_q.size() == 0) begin
                    cmp_val("extra_pair", 32'(pair_cnt), 32'hffff_ffff);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    cmp_val("pair_a", 32'(op_a), 32'(e.a));
                    cmp_val("pair_b", 32'(op_b), 32'(e.b));
                    cmp_val("pair_last", 32'(op_last), 32'(e.last));
                end
                pair_cnt++;
            end
            prev_stall = op_valid && !op_ready;
            prev_p     = '{last: op_last, a: op_a, b: op_b};
        end
    end

    task automatic start_job(input logic [3:0] sa, input logic [3:0] sb,
                             input logic [3:0] base, input logic [4:0] cnt);
        pair_t p;
        exp_q.delete();
        pair_cnt = 0; done_cnt = 0; valid_cyc = 0; busy_cyc = 0;
        job_sa = sa; job_sb = sb;
        for (int i = 0; i < int'(cnt); i++) begin
            p.a    = mem[sa][4'(int'(base) + i)];
            p.b    = mem[sb][4'(int'(base) + i)];
            p.last = (i == int'(cnt) - 1);
            exp_q.push_back(p);
        end
        sec_a = sa; sec_b = sb; base_addr = base; count = cnt; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int cyc;
        start_job(v.sa, v.sb, v.base, v.cnt);
        cyc = 0;
        while (done_cnt == 0 && cyc < 600) begin
            case (v.mode)
                0:       op_ready = 1'b1;
                1:       op_ready = (cyc % 3 == 0);
                default: op_ready = 1'($urandom_range(0, 1));
            endcase
            if (v.mid_start && (cyc == 3 || cyc == 6)) begin
                start = 1'b1;
                sec_a = 4'($urandom); sec_b = 4'($urandom);
                base_addr = 4'($urandom); count = 5'($urandom_range(1, 16));
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 600) cmp_val("job_timeout", 32'(cyc), 32'd0);
        op_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        cmp_val("pair_count", 32'(pair_cnt), 32'(v.exp_pairs));
        cmp_val("done_count", 32'(done_cnt), 32'(v.exp_dones));
        cmp_val("queue_left", 32'(exp_q.size()), 32'd0);
        cmp_val("idle_busy", 32'(busy), 32'd0);
        cmp_val("idle_valid", 32'(op_valid), 32'd0);
        if (v.cnt == 5'd0) begin
            cmp_val("zero_busy_cycles", 32'(busy_cyc), 32'd1);
            cmp_val("zero_valid_cycles", 32'(valid_cyc), 32'd0);
        end
        if (v.cnt == 5'd16) cmp_val("addr_return", 32'(read_add_1), 32'(v.base));
    endtask

    task automatic check_all_zero(input string tag);
        cmp_val({tag, "_ctl"}, {27'd0, op_valid, op_last, busy, done, 1'b0}, 32'd0);
        cmp_val({tag, "_ops"}, {op_a, op_b}, 32'd0);
        cmp_val({tag, "_rd"}, {16'd0, read_add_1, read_add_2,
                read_sector_selector_1, read_sector_selector_2}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vec_t rv;
        rst_n = 1'b0; start = 1'b0; op_ready = 1'b0;
        sec_a = '0; sec_b = '0; base_addr = '0; count = '0;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 16; w++)
                mem[s][w] = 16'($urandom);

        vecs[0] = '{4'd2, 4'd7, 4'd0,  5'd4,  0, 1'b0, 4,  1};
        vecs[1] = '{4'd1, 4'd3, 4'd14, 5'd4,  0, 1'b0, 4,  1};
        vecs[2] = '{4'd4, 4'd5, 4'd3,  5'd8,  1, 1'b0, 8,  1};
        vecs[3] = '{4'd3, 4'd3, 4'd9,  5'd0,  0, 1'b0, 0,  1};
        vecs[4] = '{4'd6, 4'd9, 4'd10, 5'd5,  0, 1'b1, 5,  1};
        vecs[5] = '{4'd8, 4'd11, 4'd5, 5'd16, 2, 1'b0, 16, 1};
        vecs[6] = '{4'd0, 4'd15, 4'd15, 5'd1, 1, 1'b0, 1,  1};

        #12;
        check_all_zero("reset");
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;

        for (int k = 0; k < 7; k++) run_job(vecs[k]);

        for (int k = 0; k < 15; k++) begin
            rv.sa = 4'($urandom); rv.sb = 4'($urandom); rv.base = 4'($urandom);
            rv.cnt = 5'($urandom_range(0, 16));
            rv.mode = 2; rv.mid_start = 1'($urandom_range(0, 1));
            rv.exp_pairs = int'(rv.cnt); rv.exp_dones = 1;
            run_job(rv);
        end

        // Abort a count=6 job right after its second accepted pair.
        start_job(4'd4, 4'd9, 4'd2, 5'd6);
        cyc = 0;
        while (pair_cnt < 2 && cyc < 200) begin
            op_ready = 1'b1;
            @(posedge clock); #1;
            cyc++;
        end
        if (cyc >= 200) cmp_val("abort_timeout", 32'(cyc), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("abort_hold");
        cmp_val("abort_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        rv = '{4'd12, 4'd1, 4'd13, 5'd3, 2, 1'b0, 3, 1};
        run_job(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
